// File: rtl/dmp_req_router_if.sv
// DMP request, target-side and load-return signals of the data-memory request router.
// The slave modport is the router's view; the master modport is the surrounding core's view.
interface dmp_req_router_if;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] dmp_addr;
    logic        req_wr;
    logic [31:0] req_wdata;
    logic        is_ldst_ram;
    logic        is_code_ram;
    logic        is_peripheral;
    logic [2:0]  tgt_sel;
    logic        tgt_valid;
    logic [31:0] tgt_addr;
    logic        tgt_wr;
    logic [31:0] tgt_wdata;
    logic        iccm_grant;
    logic        q_ready;
    logic [31:0] dccm_rdata;
    logic [31:0] iccm_rdata;
    logic        q_rvalid;
    logic [31:0] q_rdata;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        iccm_force;
    logic        busy;

    modport slave (
        input  req_valid, dmp_addr, req_wr, req_wdata,
        input  is_ldst_ram, is_code_ram, is_peripheral,
        input  iccm_grant, q_ready, dccm_rdata, iccm_rdata, q_rvalid, q_rdata,
        output req_ready, tgt_sel, tgt_valid, tgt_addr, tgt_wr, tgt_wdata,
        output ld_valid, ld_data, iccm_force, busy
    );

    modport master (
        output req_valid, dmp_addr, req_wr, req_wdata,
        output is_ldst_ram, is_code_ram, is_peripheral,
        output iccm_grant, q_ready, dccm_rdata, iccm_rdata, q_rvalid, q_rdata,
        input  req_ready, tgt_sel, tgt_valid, tgt_addr, tgt_wr, tgt_wdata,
        input  ld_valid, ld_data, iccm_force, busy
    );
endinterface

// File: rtl/dmp_req_router.sv
// Routes one DMP request at a time to DCCM, ICCM or the LD/ST queue; RAM loads return 3 cycles after capture.
// Holds the request in ISSUE until the target accepts; req_ready is low whenever a request is in flight.
module dmp_req_router #(
    parameter int ICCM_STARVE = 15
) (
    input  logic             clk,
    input  logic             rst_a,
    dmp_req_router_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, ISSUE, RDATA, WAIT_Q} state_t;

    localparam logic [2:0] SEL_DCCM  = 3'b001;
    localparam logic [2:0] SEL_ICCM  = 3'b010;
    localparam logic [2:0] SEL_Q     = 3'b100;
    localparam logic [3:0] STARVE_TH = 4'(ICCM_STARVE);

    state_t      state_q, state_d;
    logic [2:0]  tgt_sel_q, tgt_sel_d;
    logic [31:0] tgt_addr_q, tgt_addr_d;
    logic        tgt_wr_q, tgt_wr_d;
    logic [31:0] tgt_wdata_q, tgt_wdata_d;
    logic [31:0] ld_data_q, ld_data_d;
    logic        ld_valid_q, ld_valid_d;
    logic [3:0]  starve_cnt_q, starve_cnt_d;
    logic        accept;
    logic [2:0]  dec_sel;

    // Peripheral and unmapped space both fall through to the queue, so the flag needs no decoding.
    logic unused_is_peripheral;
    assign unused_is_peripheral = bus.is_peripheral;

    always_comb begin
        state_d      = state_q;
        tgt_sel_d    = tgt_sel_q;
        tgt_addr_d   = tgt_addr_q;
        tgt_wr_d     = tgt_wr_q;
        tgt_wdata_d  = tgt_wdata_q;
        ld_data_d    = ld_data_q;
        ld_valid_d   = 1'b0;
        starve_cnt_d = 4'd0;

        if (bus.is_ldst_ram)      dec_sel = SEL_DCCM;
        else if (bus.is_code_ram) dec_sel = SEL_ICCM;
        else                      dec_sel = SEL_Q;

        accept = tgt_sel_q[0]
               | (tgt_sel_q[1] & bus.iccm_grant)
               | (tgt_sel_q[2] & bus.q_ready);

        case (state_q)
            IDLE: begin
                if (bus.req_valid) begin
                    tgt_sel_d   = dec_sel;
                    tgt_addr_d  = bus.dmp_addr;
                    tgt_wr_d    = bus.req_wr;
                    tgt_wdata_d = bus.req_wdata;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (accept) begin
                    if (tgt_wr_q) begin
                        state_d   = IDLE;
                        tgt_sel_d = 3'b000;
                    end else if (tgt_sel_q[2]) begin
                        state_d = WAIT_Q;
                    end else begin
                        state_d = RDATA;
                    end
                end else if (tgt_sel_q[1]) begin
                    starve_cnt_d = (starve_cnt_q == 4'hF) ? 4'hF : starve_cnt_q + 4'd1;
                end
            end
            RDATA: begin
                ld_data_d  = tgt_sel_q[1] ? bus.iccm_rdata : bus.dccm_rdata;
                ld_valid_d = 1'b1;
                state_d    = IDLE;
                tgt_sel_d  = 3'b000;
            end
            WAIT_Q: begin
                if (bus.q_rvalid) begin
                    ld_data_d  = bus.q_rdata;
                    ld_valid_d = 1'b1;
                    state_d    = IDLE;
                    tgt_sel_d  = 3'b000;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_a) begin
        if (!rst_a) begin
            state_q      <= IDLE;
            tgt_sel_q    <= 3'b000;
            tgt_addr_q   <= 32'd0;
            tgt_wr_q     <= 1'b0;
            tgt_wdata_q  <= 32'd0;
            ld_data_q    <= 32'd0;
            ld_valid_q   <= 1'b0;
            starve_cnt_q <= 4'd0;
        end else begin
            state_q      <= state_d;
            tgt_sel_q    <= tgt_sel_d;
            tgt_addr_q   <= tgt_addr_d;
            tgt_wr_q     <= tgt_wr_d;
            tgt_wdata_q  <= tgt_wdata_d;
            ld_data_q    <= ld_data_d;
            ld_valid_q   <= ld_valid_d;
            starve_cnt_q <= starve_cnt_d;
        end
    end

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.tgt_valid  = (state_q == ISSUE);
    assign bus.busy       = (state_q != IDLE);
    assign bus.tgt_sel    = tgt_sel_q;
    assign bus.tgt_addr   = tgt_addr_q;
    assign bus.tgt_wr     = tgt_wr_q;
    assign bus.tgt_wdata  = tgt_wdata_q;
    assign bus.ld_valid   = ld_valid_q;
    assign bus.ld_data    = ld_data_q;
    // Registered count keeps the force high through the accept cycle; it drops once ISSUE is left.
    assign bus.iccm_force = (state_q == ISSUE) && tgt_sel_q[1] && (starve_cnt_q >= STARVE_TH);
endmodule
